// File: rtl/spi_slave_rx.sv
// SPI receive end: oversampled cs/sclk/mosi, one DATA_W word per chip-select frame.
// Latency: done/err are registered, one clk after the detected final sclk fall or cs rise (about 3 clk after the pin edge).
// Backpressure: none; done is a one-clk strobe and dout holds until the next done.
//
// Ports:
//   clk, rst_n      system clock, synchronous active-low reset
//   cs, sclk, mosi  SPI pins from the master, asynchronous to clk
//   dout            last complete received word
//   done            one-clk pulse, dout has just been updated
//   err             one-clk pulse, frame aborted by an early cs release
//   busy            high while a frame is in progress
//
// Build option: define SPI_SLAVE_RX_MSB_FIRST_EN to shift bits in MSB-first
// (first captured bit lands in dout[DATA_W-1]). Default is LSB-first.

module spi_slave_rx #(
    parameter int DATA_W     = 12,
    parameter int SKIP_EDGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              err,
    output logic              busy
);

    localparam int BCNT_W = $clog2(DATA_W + 1);
    // SKIP_EDGES may be 0, in which case the skip counter is unused but must
    // still have a legal width.
    localparam int SKIP_W = (SKIP_EDGES < 1) ? 1 : $clog2(SKIP_EDGES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers plus one extra stage on cs/sclk for edge detect
    // ------------------------------------------------------------------
    logic cs_s1, cs_s2, cs_prev;
    logic sclk_s1, sclk_s2, sclk_prev;
    logic mosi_s1, mosi_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // cs idles high, so its chain resets to 1 to avoid a false cs_fall
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_prev   <= 1'b1;
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
        end else begin
            cs_s1     <= cs;
            cs_s2     <= cs_s1;
            cs_prev   <= cs_s2;
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            mosi_s1   <= mosi;
            mosi_s2   <= mosi_s1;
        end
    end

    logic sclk_fall, cs_fall, cs_rise;

    assign sclk_fall = sclk_prev & ~sclk_s2;
    assign cs_fall   = cs_prev & ~cs_s2;
    assign cs_rise   = ~cs_prev & cs_s2;

    // ------------------------------------------------------------------
    // FSM and datapath state
    // ------------------------------------------------------------------
    state_t              state, state_nxt;
    logic [BCNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [SKIP_W-1:0]   skip_cnt, skip_cnt_nxt;
    logic [DATA_W-1:0]   shreg, shreg_nxt;
    logic [DATA_W-1:0]   dout_nxt;
    logic                done_nxt, err_nxt, busy_nxt;
    logic [DATA_W-1:0]   shifted;

    // The word as it would look with the current synced mosi bit shifted in.
    // Shifting (rather than indexing by bit_cnt) leaves the first bit in its
    // final position only after exactly DATA_W shifts.
`ifdef SPI_SLAVE_RX_MSB_FIRST_EN
    assign shifted = {shreg[DATA_W-2:0], mosi_s2};
`else
    assign shifted = {mosi_s2, shreg[DATA_W-1:1]};
`endif

    // The state where a new frame starts right after cs falls.
    localparam state_t FIRST_ST = (SKIP_EDGES == 0) ? SHIFT : SKIP;

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        skip_cnt_nxt = skip_cnt;
        shreg_nxt    = shreg;
        dout_nxt     = dout;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;

        case (state)
            IDLE: begin
                // sclk activity with cs high is ignored here
                if (cs_fall) begin
                    state_nxt    = FIRST_ST;
                    bit_cnt_nxt  = '0;
                    skip_cnt_nxt = '0;
                    shreg_nxt    = '0;
                end
            end

            SKIP: begin
                // cs_rise takes priority over a coincident sclk_fall
                if (cs_rise) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (sclk_fall) begin
                    skip_cnt_nxt = skip_cnt + SKIP_W'(1);
                    if (skip_cnt == SKIP_W'(SKIP_EDGES - 1)) begin
                        state_nxt = SHIFT;
                    end
                end
            end

            SHIFT: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end else if (sclk_fall) begin
                    shreg_nxt   = shifted;
                    bit_cnt_nxt = bit_cnt + BCNT_W'(1);
                    if (bit_cnt == BCNT_W'(DATA_W - 1)) begin
                        dout_nxt  = shifted;
                        done_nxt  = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end

            HOLD: begin
                // A cs_fall seen here means the rise was missed: treat it as
                // rise-then-fall and open a new frame straight away.
                if (cs_fall) begin
                    state_nxt    = FIRST_ST;
                    bit_cnt_nxt  = '0;
                    skip_cnt_nxt = '0;
                    shreg_nxt    = '0;
                end else if (cs_rise) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // busy is registered alongside state so it tracks it exactly
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            skip_cnt <= '0;
            shreg    <= '0;
            dout     <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            skip_cnt <= skip_cnt_nxt;
            shreg    <= shreg_nxt;
            dout     <= dout_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            busy     <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic [11:0] dout;
    logic        done;
    logic        err;
    logic        busy;

    int checks = 0;
    int failures = 0;

    spi_slave_rx #(.DATA_W(12), .SKIP_EDGES(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cs   (cs),
        .sclk (sclk),
        .mosi (mosi),
        .dout (dout),
        .done (done),
        .err  (err),
        .busy (busy)
    );

    always #5 clk = ~clk;

    `define CHK(tag, obs, exp) \
        begin \
            checks++; \
            assert ((obs) === (exp)) else begin \
                failures++; \
                $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
            end \
        end

    // Pulse monitor, sampled on the falling edge away from the active edge.
    int          n_done = 0;
    int          n_err = 0;
    int          n_overlap = 0;
    int          n_long = 0;
    logic        prev_done = 1'b0;
    logic        prev_err = 1'b0;
    logic [11:0] done_word = 12'h000;

    always @(negedge clk) begin
        if (done) begin
            n_done++;
            done_word = dout;
        end
        if (err) n_err++;
        if (done && err) n_overlap++;
        if ((done && prev_done) || (err && prev_err)) n_long++;
        prev_done = done;
        prev_err  = err;
    end

    // Inputs change 3 time units after a rising edge so they are never
    // coincident with the sampling clock edge.
    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    // Bit sequence a master sends for a word; the bench's model of bit order.
    function automatic logic bit_of(input logic [11:0] w, input int i);
`ifdef SPI_SLAVE_RX_MSB_FIRST_EN
        return w[11 - i];
`else
        return w[i];
`endif
    endfunction

    // One master frame: cs low, one dummy sclk period, nbits data bits, and
    // (for a complete frame) the trailing idle bit, then cs high.
    // busy_mid is sampled on the first data bit's high phase.
    task automatic spi_frame(input logic [11:0] w, input int nbits,
                             input int half, output logic busy_mid);
        busy_mid = 1'b0;
        cs = 1'b0;
        wclk(half);
        for (int i = -1; i < nbits; i++) begin
            sclk = 1'b1;
            mosi = (i < 0) ? 1'($urandom) : bit_of(w, i);
            wclk(half);
            if (i == 0) busy_mid = busy;
            sclk = 1'b0;
            wclk(half);
        end
        if (nbits == 12) begin
            sclk = 1'b1;
            mosi = 1'b1;
            wclk(half);
            sclk = 1'b0;
            wclk(half);
        end
        cs = 1'b1;
        wclk(2 * half);
    endtask

    int          d0, e0;
    logic        bm;
    logic [11:0] w;
    int          hp;

    initial begin
        // Reset
        rst_n = 1'b0;
        wclk(3);
        `CHK("rst_dout", dout, 12'h000)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_err", err, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        rst_n = 1'b1;
        wclk(5);

        // Loopback-style frame at half-period 11
        d0 = n_done; e0 = n_err;
        spi_frame(12'hA5C, 12, 11, bm);
        `CHK("a5c_busy_mid", bm, 1'b1)
        `CHK("a5c_busy_after", busy, 1'b0)
        `CHK("a5c_ndone", n_done - d0, 1)
        `CHK("a5c_nerr", n_err - e0, 0)
        `CHK("a5c_dout", dout, 12'hA5C)
        `CHK("a5c_strobe_word", done_word, 12'hA5C)

        // Back-to-back frames
        d0 = n_done;
        spi_frame(12'h001, 12, 5, bm);
        `CHK("b2b1_dout", dout, 12'h001)
        spi_frame(12'hFFF, 12, 5, bm);
        `CHK("b2b2_dout", dout, 12'hFFF)
        `CHK("b2b_ndone", n_done - d0, 2)

        // Aborted frame: skip edge plus 5 data bits, then cs high
        d0 = n_done; e0 = n_err;
        spi_frame(12'h2A5, 5, 6, bm);
        `CHK("abort_nerr", n_err - e0, 1)
        `CHK("abort_ndone", n_done - d0, 0)
        `CHK("abort_dout", dout, 12'hFFF)
        `CHK("abort_busy", busy, 1'b0)

        // sclk activity with cs high
        d0 = n_done; e0 = n_err;
        for (int i = 0; i < 20; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            wclk(4);
        end
        sclk = 1'b0;
        wclk(6);
        `CHK("idle_sclk_ndone", n_done - d0, 0)
        `CHK("idle_sclk_nerr", n_err - e0, 0)
        `CHK("idle_sclk_busy", busy, 1'b0)
        `CHK("idle_sclk_dout", dout, 12'hFFF)

        // Reset after 6 bits of a frame; cs released together with reset
        d0 = n_done; e0 = n_err;
        cs = 1'b0;
        wclk(6);
        for (int i = -1; i < 6; i++) begin
            sclk = 1'b1;
            mosi = (i < 0) ? 1'b0 : bit_of(12'h3C3, i);
            wclk(6);
            sclk = 1'b0;
            wclk(6);
        end
        rst_n = 1'b0;
        cs = 1'b1;
        wclk(1);
        rst_n = 1'b1;
        `CHK("midrst_dout", dout, 12'h000)
        `CHK("midrst_done", done, 1'b0)
        `CHK("midrst_err", err, 1'b0)
        `CHK("midrst_busy", busy, 1'b0)
        wclk(10);
        `CHK("midrst_nerr", n_err - e0, 0)
        `CHK("midrst_ndone", n_done - d0, 0)
        spi_frame(12'h3C3, 12, 6, bm);
        `CHK("post_rst_dout", dout, 12'h3C3)
        `CHK("post_rst_ndone", n_done - d0, 1)

        // Pattern whose LSB-first and MSB-first images differ
        d0 = n_done;
        spi_frame(12'h80F, 12, 4, bm);
        `CHK("w80f_dout", dout, 12'h80F)
        `CHK("w80f_ndone", n_done - d0, 1)

        // Randomized frames at random legal rates
        for (int k = 0; k < 10; k++) begin
            w  = 12'($urandom);
            hp = $urandom_range(4, 12);
            d0 = n_done; e0 = n_err;
            spi_frame(w, 12, hp, bm);
            `CHK("rand_dout", dout, w)
            `CHK("rand_ndone", n_done - d0, 1)
            `CHK("rand_nerr", n_err - e0, 0)
        end

        // Pulse shape over the whole run
        `CHK("done_err_overlap", n_overlap, 0)
        `CHK("pulse_longer_than_1clk", n_long, 0)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
